// File: rtl/latency_mem_arbiter_pkg.sv
// Shared definitions for the latency memory arbiter: FSM state encoding and
// statistics counter width.
package latency_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/latency_mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping to the lowest set request below it.
module rr_arbiter #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [CH_W-1:0]   grant_o,
    output logic              any_req_o
);

    always_comb begin
        grant_o   = '0;
        any_req_o = 1'b0;
        // Upper pass covers ptr..NUM_CH-1; lower pass supplies the wrap.
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (!any_req_o && req_i[c] && (CH_W'(c) >= ptr_i)) begin
                any_req_o = 1'b1;
                grant_o   = CH_W'(c);
            end
        end
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (!any_req_o && req_i[c]) begin
                any_req_o = 1'b1;
                grant_o   = CH_W'(c);
            end
        end
    end

endmodule

// File: rtl/latency_mem_arbiter.sv
// Round-robin arbiter of NUM_CH cache channels onto one single-port RAM with a
// fixed LATENCY wait before each access. Optional LATENCY_MEM_ARBITER_STATS_EN.
module latency_mem_arbiter
    import latency_mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_req_valid,
    input  logic [NUM_CH-1:0]        ch_req_wen,
    input  logic [NUM_CH*ADDR_W-1:0] ch_req_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_req_data,
    output logic [NUM_CH-1:0]        ch_res_valid,
    output logic [DATA_W-1:0]        ch_res_data,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     busy
`ifdef LATENCY_MEM_ARBITER_STATS_EN
    ,
    output logic [NUM_CH*STAT_W-1:0] stat_done_cnt
`endif
);

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [CH_W-1:0]    grant_q, grant_d;
    logic [CH_W-1:0]    rr_q,    rr_d;
    logic [ADDR_W-1:0]  addr_q,  addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               wen_q,   wen_d;

    logic [CH_W-1:0]    arb_grant;
    logic               arb_any;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr_arbiter (
        .req_i     (ch_req_valid),
        .ptr_i     (rr_q),
        .grant_o   (arb_grant),
        .any_req_o (arb_any)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wen_d   = wen_q;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_d = arb_grant;
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (arb_grant == CH_W'(i)) begin
                            addr_d  = ch_req_addr[i*ADDR_W +: ADDR_W];
                            wdata_d = ch_req_data[i*DATA_W +: DATA_W];
                            wen_d   = ch_req_wen[i];
                        end
                    end
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                rr_d    = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + CH_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            rr_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
        end
    end

    // Outputs decode registered state only; mem_rdata is the sole input path.
    assign busy         = (state_q != IDLE);
    assign mem_en       = (state_q == ACCESS);
    assign mem_we       = mem_en && wen_q;
    assign mem_addr     = mem_en ? addr_q  : '0;
    assign mem_wdata    = mem_en ? wdata_q : '0;
    assign ch_res_valid = (state_q == RESP) ? (NUM_CH'(1) << grant_q) : '0;
    assign ch_res_data  = ((state_q == RESP) && !wen_q) ? mem_rdata : '0;

`ifdef LATENCY_MEM_ARBITER_STATS_EN
    logic [STAT_W-1:0] stat_q [NUM_CH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if ((state_q == RESP) && (grant_q == CH_W'(i)) && (stat_q[i] != '1)) begin
                    stat_q[i] <= stat_q[i] + STAT_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_stat
        assign stat_done_cnt[g*STAT_W +: STAT_W] = stat_q[g];
    end
`endif

endmodule

// File: doc/latency_mem_arbiter.md
Name: latency_mem_arbiter

Overview:
- Parametrised successor to the single-channel latency memory controller.
- Arbitrates NUM_CH cache miss/writeback channels (e.g. I-cache and D-cache) onto one shared backing memory.
- Models a configurable access latency.
- Channel side speaks the cache memory handshake: req_valid, wen and addr/data in; res_valid and data out. Memory side drives a synchronous single-port RAM with 1-cycle read.

Parameters:
- NUM_CH, 2, number of requesting channels (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data word width.
- LATENCY, 4, wait cycles inserted before each memory access (>=1).
- CH_W, $clog2(NUM_CH), grant index width (derived, not overridden).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ch_req_valid  in  NUM_CH  per-channel request valid; held until matching res_valid.
- ch_req_wen  in  NUM_CH  per-channel write enable (1 = write).
- ch_req_addr  in  NUM_CH*ADDR_W  packed addresses; channel i at [i*ADDR_W +: ADDR_W].
- ch_req_data  in  NUM_CH*DATA_W  packed write data.
- ch_res_valid  out  NUM_CH  one-cycle done pulse to the granted channel.
- ch_res_data  out  DATA_W  read data; valid only while some ch_res_valid bit is 1.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_en.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all outputs 0.
  - Round-robin pointer rr_ptr=0; counter=0.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - If any ch_req_valid is set, grant the first set bit searching from rr_ptr upward with wrap.
  - Latch grant, addr, data and wen into internal registers; load counter=LATENCY-1; go to WAIT.
  - With no request, stay in IDLE.
- WAIT: decrement counter; at counter==0 go to ACCESS. WAIT lasts exactly LATENCY cycles.
- ACCESS:
  - mem_en=1 for one cycle; mem_we, mem_addr and mem_wdata come from latched values. Writes commit at the end of this cycle.
  - Go to RESP.
- RESP:
  - ch_res_valid[grant]=1 for one cycle.
  - ch_res_data=mem_rdata for reads, 0 for writes.
  - rr_ptr=grant+1 (wraps to 0 at NUM_CH); go to IDLE.
- Latency: a request sampled in IDLE at edge t produces res_valid during cycle t+LATENCY+2.
- Back-to-back: after RESP, IDLE spends at least one cycle. A requester whose valid is still high in IDLE is treated as a new request.
- Multiple simultaneous valids are served round-robin.
- A channel waiting for service never starves: worst-case wait is (NUM_CH-1) transactions.
- Request inputs are sampled only in IDLE. Changes to addr/data/wen while granted are ignored.
- If a requester drops valid mid-transaction, the transaction still completes and res_valid still pulses.
- Reset mid-transaction aborts it.
  - If reset is asserted before ACCESS, no memory write occurs.
  - No res_valid is emitted after reset is released.
- Outputs are registered (no combinational path from ch_req_* to mem_* or ch_res_*), except ch_res_data, which is muxed from mem_rdata.

Optional Feature:
- Macro: LATENCY_MEM_ARBITER_STATS_EN.
- Defined:
  - Adds output stat_done_cnt, NUM_CH*16 bits; channel i at [i*16 +: 16].
  - Each count increments on that channel's RESP and saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package/defs header holds:
  - FSM state encodings (IDLE=2'd0, WAIT=2'd1, ACCESS=2'd2, RESP=2'd3).
  - STAT_W=16.
- One sub-module, rr_arbiter:
  - Combinational round-robin pick from a request vector and rr_ptr.
  - Outputs grant index and any_req.
  - Reused later by the multi-core bus.

Test Plan:
- Single read: NUM_CH=2, LATENCY=4, memory preloaded [0x10]=0xDEADBEEF; ch0 reads addr 0x10 at edge 0 → ch_res_valid=2'b01 in cycle 6, ch_res_data=0xDEADBEEF; mem_en is a single pulse in cycle 5.
- Write then read: ch1 writes 0xCAFEF00D to 0x20, then ch1 reads 0x20 → first res_valid=2'b10 with data 0; second returns 0xCAFEF00D.
- Contention: ch0 and ch1 both valid at the same edge, rr_ptr=0 → ch0 served first, ch1 second, with no idle gap beyond the single IDLE cycle. Repeated simultaneous requests alternate ch1, ch0, ch1.
- Dropped request: ch0 deasserts valid during WAIT → transaction still completes and ch_res_valid[0] still pulses; busy returns to 0 afterwards.
- Reset during WAIT: ch0 write to 0x30 of 0x1234, rst=0 two cycles after grant → mem_en never asserted, memory[0x30] unchanged, all outputs 0 immediately (async).
- Stats (macro defined): 3 ch0 and 2 ch1 transactions → stat_done_cnt = {16'd2, 16'd3}.
